// File: rtl/mode_sequencer.sv
// -----------------------------------------------------------------------------
// mode_sequencer
//
// Top-level control FSM for the stopwatch / microwave timer. Turns debounced
// button pulses and timer status into the mode and sub-mode codes that steer
// the timer datapath, and produces the cook-complete pulse and buzzer enable.
// This block owns every mode / sub-mode register.
//
// Ports
//   clk              in   system clock (100 MHz)
//   reset            in   asynchronous, active-high reset
//   rise_button[4:0] in   one-cycle button pulses: [0]=U [1]=L [2]=C [3]=R [4]=D
//   stop_flag        in   WATCH_STOP has been held for 30 s
//   oven_time_zero   in   oven time reads 0:00 (registered, 1-cycle lag)
//   state[1:0]       out  00 STOPWATCH, 01 MICROWAVE, 10 AIR_HANDLE
//   watch_state[1:0] out  00 UP_COUNTER, 01 DOWN_COUNTER, 10 WATCH_STOP, 11 WATCH
//   prev_watch_state out  last running watch sub-state before WATCH_STOP
//   oven_state[2:0]  out  000 IDLE, 001 READY, 010 COOK, 011 PAUSE, 100 COOK_END
//   oven_done        out  one-cycle pulse on COOK -> COOK_END time-out
//   buzzer_en        out  high while oven_state is COOK_END
// -----------------------------------------------------------------------------
module mode_sequencer #(
    parameter int unsigned END_HOLD_CYCLES = 300_000_000,
    parameter int unsigned HOLD_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rise_button,
    input  logic       stop_flag,
    input  logic       oven_time_zero,
    output logic [1:0] state,
    output logic [1:0] watch_state,
    output logic [1:0] prev_watch_state,
    output logic [2:0] oven_state,
    output logic       oven_done,
    output logic       buzzer_en
);

    typedef enum logic [1:0] {
        MODE_STOPWATCH  = 2'b00,
        MODE_MICROWAVE  = 2'b01,
        MODE_AIR_HANDLE = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        W_UP    = 2'b00,
        W_DOWN  = 2'b01,
        W_STOP  = 2'b10,
        W_WATCH = 2'b11
    } watch_t;

    typedef enum logic [2:0] {
        O_IDLE     = 3'b000,
        O_READY    = 3'b001,
        O_COOK     = 3'b010,
        O_PAUSE    = 3'b011,
        O_COOK_END = 3'b100
    } oven_t;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_C = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD_CYCLES - 1);

    mode_t             r_state;
    watch_t            r_watch_state;
    watch_t            r_prev_watch_state;
    oven_t             r_oven_state;
    logic              r_oven_done;
    logic              r_buzzer_en;
    logic [HOLD_W-1:0] r_hold;

    // R is refused while cooking; when it is accepted it swallows every other
    // button of that cycle, so the sub-FSMs see an all-zero button vector.
    logic       w_r_accept;
    logic [4:0] w_btn_eff;
    logic       w_watch_act;
    logic       w_oven_act;

    assign w_r_accept  = rise_button[BTN_R] && (r_oven_state != O_COOK);
    assign w_btn_eff   = w_r_accept ? 5'b00000 : rise_button;
    assign w_watch_act = (r_state == MODE_STOPWATCH);
    assign w_oven_act  = (r_state == MODE_MICROWAVE);

    // NOTE: every register here is sequential state, so it is assigned with
    // non-blocking <= only; blocking writes would make same-edge reads order-dependent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= MODE_STOPWATCH;
            r_watch_state      <= W_STOP;
            r_prev_watch_state <= W_UP;
            r_oven_state       <= O_IDLE;
            r_oven_done        <= 1'b0;
            r_buzzer_en        <= 1'b0;
            r_hold             <= '0;
        end else begin
            r_oven_done <= 1'b0;

            if (w_r_accept) begin
                case (r_state)
                    MODE_STOPWATCH: r_state <= MODE_MICROWAVE;
                    MODE_MICROWAVE: r_state <= MODE_AIR_HANDLE;
                    default:        r_state <= MODE_STOPWATCH;
                endcase
            end

            // Watch sub-FSM. Buttons are tested C > U > D > L; the first one
            // that has a transition from the current state wins.
            case (r_watch_state)
                W_STOP: begin
                    if (w_watch_act && w_btn_eff[BTN_C])      r_watch_state <= r_prev_watch_state;
                    else if (w_watch_act && w_btn_eff[BTN_U]) r_watch_state <= W_UP;
                    else if (w_watch_act && w_btn_eff[BTN_D]) r_watch_state <= W_DOWN;
                    else if (stop_flag)                       r_watch_state <= W_WATCH;
                end
                W_UP: begin
                    if (w_watch_act && w_btn_eff[BTN_C]) begin
                        r_watch_state      <= W_STOP;
                        r_prev_watch_state <= W_UP;
                    end
                    else if (w_watch_act && w_btn_eff[BTN_D]) r_watch_state <= W_DOWN;
                    else if (w_watch_act && w_btn_eff[BTN_L]) r_watch_state <= W_WATCH;
                end
                W_DOWN: begin
                    if (w_watch_act && w_btn_eff[BTN_C]) begin
                        r_watch_state      <= W_STOP;
                        r_prev_watch_state <= W_DOWN;
                    end
                    else if (w_watch_act && w_btn_eff[BTN_U]) r_watch_state <= W_UP;
                    else if (w_watch_act && w_btn_eff[BTN_L]) r_watch_state <= W_WATCH;
                end
                W_WATCH: begin
                    if (w_watch_act && w_btn_eff[BTN_C]) begin
                        r_watch_state      <= W_STOP;
                        r_prev_watch_state <= W_WATCH;
                    end
                    else if (w_watch_act && w_btn_eff[BTN_L]) r_watch_state <= W_UP;
                end
            endcase

            // Oven sub-FSM. buzzer_en mirrors COOK_END, so it is set on every
            // entry and cleared on every exit alongside the hold counter.
            case (r_oven_state)
                O_IDLE: begin
                    if (w_oven_act && w_btn_eff[BTN_U]) r_oven_state <= O_READY;
                end
                O_READY: begin
                    if (w_oven_act && w_btn_eff[BTN_C]) begin
                        if (!oven_time_zero) r_oven_state <= O_COOK;
                    end
                    // Time reached zero (e.g. after D cleared it) and nothing is
                    // being pressed: fall back to IDLE.
                    else if (w_oven_act && oven_time_zero && (rise_button == 5'b00000)) begin
                        r_oven_state <= O_IDLE;
                    end
                end
                O_COOK: begin
                    if (oven_time_zero) begin
                        r_oven_state <= O_COOK_END;
                        r_oven_done  <= 1'b1;
                        r_buzzer_en  <= 1'b1;
                        r_hold       <= '0;
                    end
                    else if (w_oven_act && w_btn_eff[BTN_C]) r_oven_state <= O_PAUSE;
                end
                O_PAUSE: begin
                    if (w_oven_act && w_btn_eff[BTN_C]) r_oven_state <= O_COOK;
                    else if (w_oven_act && w_btn_eff[BTN_L]) begin
                        r_oven_state <= O_COOK_END;
                        r_buzzer_en  <= 1'b1;
                        r_hold       <= '0;
                    end
                end
                O_COOK_END: begin
                    // Hold time runs in every mode; buttons cut it short only in
                    // MICROWAVE. The counter stops at HOLD_LAST and never wraps.
                    if ((w_oven_act && (w_btn_eff != 5'b00000)) || (r_hold == HOLD_LAST)) begin
                        r_oven_state <= O_IDLE;
                        r_buzzer_en  <= 1'b0;
                        r_hold       <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_oven_state <= O_IDLE;
                    r_buzzer_en  <= 1'b0;
                    r_hold       <= '0;
                end
            endcase
        end
    end

    assign state            = r_state;
    assign watch_state      = r_watch_state;
    assign prev_watch_state = r_prev_watch_state;
    assign oven_state       = r_oven_state;
    assign oven_done        = r_oven_done;
    assign buzzer_en        = r_buzzer_en;

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Top-level control FSM for the stopwatch/microwave timer datapath.
- Turns debounced button pulses and datapath status into the `state`, `watch_state`, `prev_watch_state` and `oven_state` codes that drive the timer.
- Produces the cook-complete pulse and the buzzer enable.
- Sits between the button edge detectors and the timer block, and is the sole owner of every mode/sub-mode register.

Parameters:
END_HOLD_CYCLES, 300_000_000, clk cycles spent in COOK_END before returning to IDLE (3 s at 100 MHz)
HOLD_W, 32, width of the COOK_END hold counter

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high
rise_button  input  5  one-cycle button pulses: [0]=U, [1]=L, [2]=C, [3]=R, [4]=D
stop_flag  input  1  from timer; high once WATCH_STOP has been held for 30 s
oven_time_zero  input  1  from timer; high when oven minutes == 0 and seconds == 0 (registered, so 1-cycle lag)
state  output  2  top mode: 00 STOPWATCH, 01 MICROWAVE, 10 AIR_HANDLE
watch_state  output  2  00 UP_COUNTER, 01 DOWN_COUNTER, 10 WATCH_STOP, 11 WATCH
prev_watch_state  output  2  last running watch sub-state before WATCH_STOP
oven_state  output  3  000 IDLE, 001 READY, 010 COOK, 011 PAUSE, 100 COOK_END
oven_done  output  1  one-cycle pulse on entry to COOK_END from COOK via time-out
buzzer_en  output  1  high while oven_state == COOK_END

Behaviour:
Interface and reset:
- Clock is `clk`; reset is `reset`, asynchronous, active-high.
- All outputs are registered.
- Reset values: `state`=STOPWATCH, `watch_state`=WATCH_STOP, `prev_watch_state`=UP_COUNTER, `oven_state`=IDLE, `oven_done`=0, `buzzer_en`=0, hold counter=0.
- Reset asserted mid-operation (e.g. during COOK or the COOK_END hold) returns every register to its reset value immediately.
- No pulse is emitted on reset release.

Per-cycle priority:
- Evaluated in this order: reset > R (mode switch) > sub-FSM events.
- A cycle in which R is accepted ignores all other buttons.
- Within a sub-FSM, buttons are prioritised C > U > D > L.
- Only one transition happens per cycle.

Mode FSM:
- R steps STOPWATCH -> MICROWAVE -> AIR_HANDLE -> STOPWATCH.
- R is ignored (and consumed) while `oven_state` == COOK.
- `watch_state` and `oven_state` hold their values while their mode is inactive.

Watch sub-FSM (buttons act only when `state` == STOPWATCH):
- WATCH_STOP:
  - C -> `prev_watch_state` (resume).
  - U -> UP_COUNTER.
  - D -> DOWN_COUNTER.
  - `stop_flag` == 1 -> WATCH; this applies in any mode and is checked after buttons.
- UP_COUNTER, DOWN_COUNTER, WATCH:
  - C -> WATCH_STOP, and `prev_watch_state` <= current state on the same edge.
- UP_COUNTER: D -> DOWN_COUNTER.
- DOWN_COUNTER: U -> UP_COUNTER.
- UP_COUNTER, DOWN_COUNTER: L -> WATCH.
- WATCH: L -> UP_COUNTER.
- `prev_watch_state` changes only on entry to WATCH_STOP, so it is never WATCH_STOP itself.

Oven sub-FSM (buttons act only when `state` == MICROWAVE):
- IDLE:
  - U -> READY. The timer adds 30 s on the same edge.
  - D and C are ignored.
- READY:
  - C with `oven_time_zero` == 0 -> COOK.
  - C with `oven_time_zero` == 1 -> stays in READY.
  - `oven_time_zero` == 1 with no button pulse this cycle -> IDLE. This covers a D that cleared the time; the exit occurs one cycle later because of the input lag.
- COOK:
  - `oven_time_zero` == 1 -> COOK_END, with `oven_done` pulsed. Time-out has priority over C.
  - Otherwise C -> PAUSE.
- PAUSE:
  - C -> COOK.
  - L (cancel) -> COOK_END, with no `oven_done` pulse.
- COOK_END:
  - Hold counter counts 0..END_HOLD_CYCLES-1.
  - At terminal count -> IDLE.
  - Any button pulse other than R -> IDLE early.
  - The counter clears on entry and exit.
- COOK_END timing advances regardless of `state`.

Width rules:
- Hold counter is HOLD_W bits and saturates at the terminal value; it never wraps.

Test Plan:
1. Mode cycling: reset, then R pulse x3 -> `state` goes 00, 01, 10, 00. Then enter COOK and pulse R -> `state` stays 01.
2. Watch stop/resume:
   - In STOPWATCH, C then U -> UP_COUNTER.
   - C -> WATCH_STOP with prev=00.
   - D -> DOWN_COUNTER.
   - C -> WATCH_STOP with prev=01.
   - C -> DOWN_COUNTER.
3. Idle timeout: in WATCH_STOP, assert `stop_flag` for 1 cycle -> next cycle WATCH. Then C -> WATCH_STOP with prev=11.
4. Cook flow (END_HOLD_CYCLES=10):
   - In MICROWAVE: U -> READY.
   - C with time_zero=0 -> COOK.
   - Raise time_zero -> COOK_END next edge, `oven_done` high exactly 1 cycle, `buzzer_en` high for 10 cycles.
   - Then IDLE with `buzzer_en`=0.
5. Pause/cancel and early exit:
   - COOK, C -> PAUSE; C -> COOK; C -> PAUSE; L -> COOK_END with `oven_done` staying 0.
   - U pulse at hold count 3 -> IDLE next edge.
6. Simultaneous and async reset:
   - rise_button=5'b01100 (C+R) in READY -> `state` advances, `oven_state` stays READY.
   - Async reset asserted mid-COOK_END -> all outputs at reset values before the next clk edge.
